// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: issues FIFO reads, absorbs 1-cycle read latency, 2-entry skid buffer.
// Optional delivered-word counter enabled by defining FIFO_DRAIN_CNT_EN.
module fifo_drain_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           word_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  inflight_q;
    logic [1:0]            buf_cnt;
    logic [2:0]            level;
    logic                  pop;

    assign m_valid = (state_q != EMPTY);
    assign m_data  = buf0_q;
    assign pop     = m_valid && m_ready;

    always_comb begin
        case (state_q)
            ONE:     buf_cnt = 2'd1;
            TWO:     buf_cnt = 2'd2;
            default: buf_cnt = 2'd0;
        endcase
    end

    // Projected occupancy after this edge; pop implies buf_cnt >= 1, so no underflow.
    assign level      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = !rst && en && !fifo_empty && (level < 3'd2);

    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            EMPTY: begin
                if (inflight_q) begin
                    buf0_d  = fifo_dout;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({inflight_q, pop})
                    2'b10: begin
                        buf1_d  = fifo_dout;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: buf0_d = fifo_dout;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    buf0_d  = buf1_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            buf0_q     <= '0;
            buf1_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            inflight_q <= fifo_rd_en;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO (1-cycle registered read).
// Counter expectations follow FIFO_DRAIN_CNT_EN.
module tb_fifo_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, fifo_empty, m_ready;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en, m_valid;
    logic [7:0] m_data;
    logic [15:0] word_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];
    logic [7:0] outq[$];
    logic       hold_prev, rst_prev;
    logic [7:0] data_prev;

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_DRAIN_CNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: monitor at negedge, FIFO model updated just after posedge.
    task automatic tick();
        logic rd, rs;
        @(negedge clk);
        rd = fifo_rd_en;
        rs = rst;
        check("no_cap_in_two", 32'(dut.buf_cnt == 2'd2 && dut.inflight_q), 32'd0);
        if (hold_prev && !rst_prev) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(data_prev));
        end
        if (m_valid && m_ready) outq.push_back(m_data);
        hold_prev = m_valid && !m_ready;
        data_prev = m_data;
        rst_prev  = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            fq.delete();
            fifo_dout = '0;
        end else if (rd) begin
            fifo_dout = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;
        hold_prev = 1'b0; rst_prev = 1'b1; data_prev = '0;
        tick(); tick();
        check("rst_rd", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);

        // Scenario 1: streaming with sink always ready
        en = 1'b1; m_ready = 1'b1;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        #1;
        check("rst_blocks_rd", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        #1;
        outq.delete();
        check("s1_rd0", 32'(fifo_rd_en), 32'd1);
        tick();
        check("s1_lat1", 32'(m_valid), 32'd0);
        tick();
        check("s1_v1", 32'(m_valid), 32'd1);
        check("s1_d1", 32'(m_data), 32'hA1);
        tick();
        check("s1_d2", 32'(m_data), 32'hA2);
        tick();
        check("s1_d3", 32'(m_data), 32'hA3);
        check("s1_rd_empty", 32'(fifo_rd_en), 32'd0);
        tick();
        check("s1_d4", 32'(m_data), 32'hA4);
        check("s1_v4", 32'(m_valid), 32'd1);
        tick();
        check("s1_vend", 32'(m_valid), 32'd0);
        check("s1_cnt", 32'(word_cnt), exp_cnt(4));

        // Scenario 2: backpressure for 6 cycles
        m_ready = 1'b0;
        outq.delete();
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        repeat (6) tick();
        check("s2_bufcnt", 32'(dut.buf_cnt), 32'd2);
        check("s2_rd_hold", 32'(fifo_rd_en), 32'd0);
        check("s2_v", 32'(m_valid), 32'd1);
        check("s2_d", 32'(m_data), 32'hA1);
        m_ready = 1'b1;
        repeat (10) tick();
        check("s2_n", 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4 && i < outq.size(); i++)
            check("s2_word", 32'(outq[i]), 32'(8'hA1 + i));
        check("s2_cnt", 32'(word_cnt), exp_cnt(8));

        // Scenario 3: sink toggling ready, 16 words
        outq.delete();
        for (int i = 0; i < 16; i++) load(8'(i));
        for (int c = 0; c < 60; c++) begin
            m_ready = (c % 2 == 0);
            tick();
        end
        check("s3_n", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16 && i < outq.size(); i++)
            check("s3_word", 32'(outq[i]), 32'(i));
        check("s3_cnt", 32'(word_cnt), exp_cnt(24));

        // Scenario 4: enable dropped after one read issue
        m_ready = 1'b1;
        en = 1'b0;
        tick();
        outq.delete();
        load(8'hB1); load(8'hB2); load(8'hB3);
        #1;
        check("s4_rd_off", 32'(fifo_rd_en), 32'd0);
        en = 1'b1;
        #1;
        check("s4_rd_on", 32'(fifo_rd_en), 32'd1);
        tick();
        en = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("s4_no_rd", 32'(fifo_rd_en), 32'd0);
            tick();
        end
        check("s4_n1", 32'(outq.size()), 32'd1);
        if (outq.size() > 0) check("s4_w1", 32'(outq[0]), 32'hB1);
        en = 1'b1;
        repeat (8) tick();
        check("s4_n3", 32'(outq.size()), 32'd3);
        if (outq.size() >= 3) begin
            check("s4_w2", 32'(outq[1]), 32'hB2);
            check("s4_w3", 32'(outq[2]), 32'hB3);
        end
        check("s4_cnt", 32'(word_cnt), exp_cnt(27));

        // Scenario 5: reset while two words are buffered
        m_ready = 1'b0;
        outq.delete();
        load(8'hC1); load(8'hC2); load(8'hC3);
        repeat (3) tick();
        check("s5_full", 32'(dut.buf_cnt), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("s5_v", 32'(m_valid), 32'd0);
        check("s5_cnt0", 32'(word_cnt), 32'd0);
        check("s5_bufcnt", 32'(dut.buf_cnt), 32'd0);
        load(8'h55);
        m_ready = 1'b1;
        repeat (8) tick();
        check("s5_n", 32'(outq.size()), 32'd1);
        if (outq.size() > 0) check("s5_w", 32'(outq[0]), 32'h55);
        check("s5_cnt", 32'(word_cnt), exp_cnt(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Downstream read-side controller for the memory-based FIFO. Watches the FIFO `empty` flag, issues `rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream with a 2-entry skid buffer. Sustains one word per cycle when the sink is always ready and never loses or duplicates a word under backpressure.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO `DATA_WIDTH`.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high; shared with the FIFO.
- `en`  in  1  drain enable; low stops new FIFO reads.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  DATA_WIDTH  FIFO `dout`; valid the cycle after `fifo_rd_en` was sampled high.
- `fifo_rd_en`  out  1  FIFO read strobe; drives FIFO `rd_en`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  sink accepts the word when `m_valid && m_ready`.
- `word_cnt`  out  16  count of words delivered (see Configuration).

## Operation
- Internal state: `inflight` (0/1, a read issued last cycle), skid buffer `buf[0:1]` with `buf_cnt` (0..2); buffer state EMPTY / ONE / TWO.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = !rst && en && !fifo_empty && (buf_cnt + inflight - pop < 2)`. Combinational; the `m_ready -> fifo_rd_en` path is intentional.
- `inflight <= fifo_rd_en` each cycle.
- When `inflight` is 1, `fifo_dout` is written into the buffer tail in that cycle.
- `m_valid = (buf_cnt != 0)`. `m_data = buf[0]`, registered.
- Transitions:
  - EMPTY: capture -> ONE.
  - ONE: capture without pop -> TWO; pop without capture -> EMPTY; both -> ONE, with head = new word.
  - TWO: pop -> ONE, with `buf[1]` shifting to head.
  - TWO never captures; the issue rule guarantees this. Reaching capture in TWO is a design error, and the bench asserts it never happens.
- Stream rule: while `m_valid && !m_ready`, `m_data` and `m_valid` hold stable.
- `en` deasserted: no new reads. An in-flight word is still captured, and buffered words still drain.
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `buf_cnt`=0, `inflight`=0, `word_cnt`=0.
- Reset mid-operation: in-flight and buffered words are discarded, because the FIFO is reset by the same `rst`. Operation resumes on the first cycle with `rst` low.

## Timing
- Read latency: `fifo_rd_en` high at edge N -> `fifo_dout` valid in cycle N+1 -> captured at edge N+1 -> `m_valid` high in cycle N+2 (2 cycles).
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- `fifo_empty` rising the cycle after the last read: no further `fifo_rd_en`, no bubble words emitted.
- Simultaneous capture and pop in state ONE: the head is replaced in the same edge; `m_valid` stays 1.

## Configuration
- Macro: `FIFO_DRAIN_CNT_EN`.
- Defined: `word_cnt` increments on every `pop` and wraps 16'hFFFF -> 16'h0000. Reset clears it to 0.
- Undefined: no counter logic; `word_cnt` is tied to 16'h0000.

## Test plan
- Reset, then FIFO preloaded with 8'hA1..8'hA4, `en`=1, `m_ready`=1: first `m_valid` 2 cycles after the first `fifo_rd_en`. Output is A1, A2, A3, A4 on consecutive cycles, and `word_cnt`=4 with the macro defined.
- Same preload, `m_ready`=0 for 6 cycles, then 1: `buf_cnt` reaches 2 and `fifo_rd_en` stays low. `m_data`=A1 held stable. After release the output is A1..A4 with no loss and no duplicate.
- `m_ready` toggling 1,0,1,0 with 16 words 8'h00..8'h0F: the output sequence is exactly 00..0F in order, and capture in state TWO never occurs.
- `en` dropped the cycle after a read issue: the in-flight word is still delivered, and no further `fifo_rd_en` occurs until `en`=1.
- `rst` pulsed for 1 cycle while the buffer holds 2 words: next cycle `m_valid`=0 and `word_cnt`=0. After the FIFO is refilled with 8'h55, the output is 8'h55 only.
- Macro undefined: the first scenario gives `word_cnt`=0 throughout.
